// File: rtl/frame_extrema.sv
// ---------------------------------------------------------------------------
// frame_extrema
//
// Streaming reducer placed after the registered min/max comparator stage.
// Every accepted (in_min, in_max) pair is folded into a running frame
// minimum and maximum. A frame closes when FRAME pairs have been taken, or
// earlier on a flush pulse. The closed frame's minimum, maximum, range and
// pair count are presented on a valid/ready output port. The next frame keeps
// accumulating while a result waits. Input stalls only when that next frame
// would complete before the waiting result has been taken.
//
// Parameters
//   DATA   width of sample values (unsigned)
//   FRAME  pairs per frame, 2..65535
//   CNT_W  width of the pair counter and of out_count
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     in_min/in_max valid this cycle
//   in_ready     pair accepted this cycle when in_valid is also high
//   in_min       candidate minimum
//   in_max       candidate maximum
//   flush        single-cycle request to close the current frame early
//   out_valid    result registers hold an unconsumed frame result
//   out_ready    consumer takes the result this cycle
//   frame_min    minimum of the frame's in_min values
//   frame_max    maximum of the frame's in_max values
//   frame_range  frame_max - frame_min, modulo 2^DATA
//   out_count    number of pairs in the frame (1..FRAME)
// ---------------------------------------------------------------------------
module frame_extrema #(
    parameter int DATA  = 8,
    parameter int FRAME = 16,
    parameter int CNT_W = $clog2(FRAME + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATA-1:0]  in_min,
    input  logic [DATA-1:0]  in_max,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATA-1:0]  frame_min,
    output logic [DATA-1:0]  frame_max,
    output logic [DATA-1:0]  frame_range,
    output logic [CNT_W-1:0] out_count
);

    // Count value at which the next accepted pair completes a frame.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    // Accumulator state
    logic [DATA-1:0]  acc_min_q, acc_min_d;
    logic [DATA-1:0]  acc_max_q, acc_max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Result registers
    logic             out_valid_q, out_valid_d;
    logic [DATA-1:0]  frame_min_q, frame_min_d;
    logic [DATA-1:0]  frame_max_q, frame_max_d;
    logic [DATA-1:0]  frame_range_q, frame_range_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    // Intermediate reduction terms
    logic             accept;
    logic             out_free;
    logic             count_close;
    logic             flush_close;
    logic             frame_close;
    logic [DATA-1:0]  red_min;
    logic [DATA-1:0]  red_max;
    logic [CNT_W-1:0] new_cnt;

    // in_ready depends only on registered state and reset, never on
    // out_ready. The one case that must stall is a pending result with the
    // accumulator one pair short of a full frame: accepting that pair would
    // need somewhere to put a second result.
    assign in_ready = !rst && !(out_valid_q && (cnt_q == LAST_CNT));

    // Combine the current accumulator with an accepted pair. An empty
    // accumulator (cnt==0) is seeded directly from the pair, so old
    // accumulator contents never leak into a new frame. in_min and in_max
    // are reduced independently, with no ordering check between them.
    always_comb begin
        accept   = in_valid && in_ready;
        out_free = !out_valid_q || out_ready;

        red_min = acc_min_q;
        red_max = acc_max_q;
        new_cnt = cnt_q;

        if (accept) begin
            new_cnt = cnt_q + 1'b1;
            if (cnt_q == '0) begin
                red_min = in_min;
                red_max = in_max;
            end else begin
                red_min = (in_min < acc_min_q) ? in_min : acc_min_q;
                red_max = (in_max > acc_max_q) ? in_max : acc_max_q;
            end
        end

        // A full-count close cannot collide with a blocked output, because
        // in_ready is low in that situation. A flush closes only when there
        // is at least one pair, counting a pair arriving in the same cycle,
        // and the result slot is free or being emptied this cycle. A flush
        // that cannot take effect yet is ignored, and upstream repeats it.
        count_close = accept && (cnt_q == LAST_CNT);
        flush_close = flush && (new_cnt != '0) && out_free;
        frame_close = count_close || flush_close;
    end

    // Next-state for the accumulator and result registers. By default the
    // result is held and out_valid drops only on an output transfer. A frame
    // close overrides this, so a transfer and a close in the same cycle leave
    // out_valid high with the new frame's values loaded.
    always_comb begin
        acc_min_d     = red_min;
        acc_max_d     = red_max;
        cnt_d         = new_cnt;
        out_valid_d   = out_valid_q && !out_ready;
        frame_min_d   = frame_min_q;
        frame_max_d   = frame_max_q;
        frame_range_d = frame_range_q;
        out_count_d   = out_count_q;

        if (frame_close) begin
            out_valid_d   = 1'b1;
            frame_min_d   = red_min;
            frame_max_d   = red_max;
            frame_range_d = red_max - red_min;
            out_count_d   = new_cnt;
            cnt_d         = '0;
        end
    end

    // State registers. Reset discards any partial frame and any pending
    // result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_min_q     <= '0;
            acc_max_q     <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            frame_min_q   <= '0;
            frame_max_q   <= '0;
            frame_range_q <= '0;
            out_count_q   <= '0;
        end else begin
            acc_min_q     <= acc_min_d;
            acc_max_q     <= acc_max_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            frame_min_q   <= frame_min_d;
            frame_max_q   <= frame_max_d;
            frame_range_q <= frame_range_d;
            out_count_q   <= out_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign frame_min   = frame_min_q;
    assign frame_max   = frame_max_q;
    assign frame_range = frame_range_q;
    assign out_count   = out_count_q;

endmodule

// File: tb/tb_frame_extrema.sv
// ---------------------------------------------------------------------------
// tb_frame_extrema
//
// Directed bench for frame_extrema with FRAME=4, DATA=8. Inputs are driven
// and outputs sampled 1 time unit after each rising clock edge. Expected
// values are hand-computed from the pair sequences applied.
// ---------------------------------------------------------------------------
module tb_frame_extrema;

    localparam int DATA  = 8;
    localparam int FRAME = 4;
    localparam int CNT_W = $clog2(FRAME + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DATA-1:0]  in_min;
    logic [DATA-1:0]  in_max;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [DATA-1:0]  frame_min;
    logic [DATA-1:0]  frame_max;
    logic [DATA-1:0]  frame_range;
    logic [CNT_W-1:0] out_count;

    int checks;
    int errors;

    frame_extrema #(
        .DATA (DATA),
        .FRAME(FRAME)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_min     (in_min),
        .in_max     (in_max),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_min  (frame_min),
        .frame_max  (frame_max),
        .frame_range(frame_range),
        .out_count  (out_count)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Compare the full result port against one expected frame.
    task automatic check_result(input string tag, input logic [31:0] vld,
                                input logic [31:0] mn, input logic [31:0] mx,
                                input logic [31:0] rg, input logic [31:0] cnt);
        check_output({tag, ".out_valid"},   32'(out_valid),   vld);
        check_output({tag, ".frame_min"},   32'(frame_min),   mn);
        check_output({tag, ".frame_max"},   32'(frame_max),   mx);
        check_output({tag, ".frame_range"}, 32'(frame_range), rg);
        check_output({tag, ".out_count"},   32'(out_count),   cnt);
    endtask

    // Present one pair for one cycle. fl drives flush in the same cycle.
    task automatic apply_stimulus(input logic [7:0] mn, input logic [7:0] mx,
                                  input logic fl);
        in_valid = 1'b1;
        in_min   = mn;
        in_max   = mx;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_min    = '0;
        in_max    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check_output("reset.in_ready", 32'(in_ready), 0);
        check_result("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check_output("post_reset.in_ready", 32'(in_ready), 1);

        // Basic frame with out_ready=1
        $display("[TB] basic frame");
        apply_stimulus(8'd10, 8'd20, 1'b0);
        apply_stimulus(8'd5,  8'd30, 1'b0);
        apply_stimulus(8'd7,  8'd8,  1'b0);
        check_output("basic.not_yet_valid", 32'(out_valid), 0);
        apply_stimulus(8'd12, 8'd25, 1'b0);
        check_result("basic", 1, 5, 30, 25, 4);
        tick();
        check_output("basic.valid_drops", 32'(out_valid), 0);

        // Backpressure: frame 1 waits while frame 2 fills to cnt==3
        $display("[TB] backpressure");
        out_ready = 1'b0;
        apply_stimulus(8'd1, 8'd10, 1'b0);
        apply_stimulus(8'd2, 8'd20, 1'b0);
        apply_stimulus(8'd3, 8'd30, 1'b0);
        apply_stimulus(8'd4, 8'd40, 1'b0);
        check_result("bp.frame1", 1, 1, 40, 39, 4);
        check_output("bp.ready_frame2_start", 32'(in_ready), 1);
        apply_stimulus(8'd5, 8'd50, 1'b0);
        apply_stimulus(8'd6, 8'd60, 1'b0);
        apply_stimulus(8'd7, 8'd70, 1'b0);
        check_output("bp.stall", 32'(in_ready), 0);
        // Hold the closing pair valid while stalled
        in_valid = 1'b1;
        in_min   = 8'd8;
        in_max   = 8'd80;
        tick();
        check_output("bp.still_stalled", 32'(in_ready), 0);
        check_result("bp.frame1_held", 1, 1, 40, 39, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output("bp.taken", 32'(out_valid), 0);
        check_output("bp.ready_back", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check_result("bp.frame2", 1, 5, 80, 75, 4);
        out_ready = 1'b1;
        tick();
        check_output("bp.frame2_taken", 32'(out_valid), 0);

        // Flush closes a short frame; flush on an empty frame does nothing
        $display("[TB] flush");
        apply_stimulus(8'd100, 8'd200, 1'b0);
        apply_stimulus(8'd50,  8'd60,  1'b1);
        check_result("flush", 1, 50, 200, 150, 2);
        tick();
        check_output("flush.valid_drops", 32'(out_valid), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("flush.empty", 32'(out_valid), 0);
        tick();
        check_output("flush.empty_later", 32'(out_valid), 0);

        // Extreme values
        $display("[TB] extremes");
        for (int i = 0; i < FRAME; i++) apply_stimulus(8'd0, 8'd255, 1'b0);
        check_result("ext.full_range", 1, 0, 255, 255, 4);
        for (int i = 0; i < FRAME; i++) apply_stimulus(8'h80, 8'h80, 1'b0);
        check_result("ext.zero_range", 1, 128, 128, 0, 4);
        tick();

        // Reset mid-frame discards the partial frame
        $display("[TB] mid-frame reset");
        apply_stimulus(8'd1, 8'd2, 1'b0);
        apply_stimulus(8'd3, 8'd4, 1'b0);
        rst = 1'b1;
        tick();
        check_output("rst.in_ready", 32'(in_ready), 0);
        check_result("rst.during", 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check_output("rst.ready_after", 32'(in_ready), 1);
        apply_stimulus(8'd9, 8'd9, 1'b0);
        check_result("rst.after", 0, 0, 0, 0, 0);
        apply_stimulus(8'd9, 8'd9, 1'b0);
        apply_stimulus(8'd9, 8'd9, 1'b0);
        check_output("rst.no_early_close", 32'(out_valid), 0);
        apply_stimulus(8'd9, 8'd9, 1'b0);
        check_result("rst.frame", 1, 9, 9, 0, 4);
        tick();

        // Blocked flush is ignored; output transfer and close in one cycle
        $display("[TB] simultaneous transfer and close");
        out_ready = 1'b0;
        apply_stimulus(8'd10, 8'd100, 1'b0);
        apply_stimulus(8'd20, 8'd90,  1'b0);
        apply_stimulus(8'd30, 8'd80,  1'b0);
        apply_stimulus(8'd40, 8'd70,  1'b0);
        check_result("sim.frame1", 1, 10, 100, 90, 4);
        apply_stimulus(8'd1, 8'd5, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_result("sim.blocked_flush", 1, 10, 100, 90, 4);
        apply_stimulus(8'd2, 8'd6, 1'b0);
        out_ready = 1'b1;
        apply_stimulus(8'd3, 8'd7, 1'b1);
        check_result("sim.frame2", 1, 1, 7, 6, 3);
        tick();
        check_output("sim.frame2_taken", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_extrema.md
# frame_extrema

Streaming accumulator downstream of the registered min/max comparator stage. It consumes one (min, max) pair per accepted cycle and reduces a frame of up to FRAME pairs to a single frame minimum, frame maximum and range. Results are presented on a valid/ready output port. The block keeps accumulating the next frame while a result is pending, and stalls only when a second frame would complete before the first result is taken.

## Interface
- DATA, 8: width of sample values, unsigned.
- FRAME, 16: pairs per frame; legal range 2..65535.
- CNT_W, $clog2(FRAME+1): width of the pair counter and of out_count.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_min/in_max valid this cycle.
- in_ready  out  1  block accepts the pair this cycle; a transfer occurs when in_valid && in_ready.
- in_min  in  DATA  candidate minimum (comparator Min output).
- in_max  in  DATA  candidate maximum (comparator Max output).
- flush  in  1  close the current frame early; single-cycle pulse.
- out_valid  out  1  result registers hold an unconsumed frame result.
- out_ready  in  1  consumer takes the result; a transfer occurs when out_valid && out_ready.
- frame_min  out  DATA  minimum of all accepted in_min values in the frame.
- frame_max  out  DATA  maximum of all accepted in_max values in the frame.
- frame_range  out  DATA  frame_max - frame_min, modulo 2^DATA.
- out_count  out  CNT_W  number of pairs in the frame (1..FRAME).

## Operation
- Accumulator: acc_min, acc_max and cnt (0..FRAME-1). The accumulator state is EMPTY when cnt==0 and FILLING when cnt>0.
- On an accepted pair with cnt==0: acc_min=in_min, acc_max=in_max, cnt=1.
- On an accepted pair with cnt>0: acc_min=min(acc_min,in_min), acc_max=max(acc_max,in_max), cnt+1. All comparisons are unsigned.
- in_min and in_max are reduced independently. No in_min<=in_max check is made.
- Frame close occurs on either of these conditions:
  - an accepted pair that brings the count to FRAME, or
  - flush with at least one pair in the frame, counting a pair accepted in the same cycle.
- On frame close:
  - the result registers load the reduction including any same-cycle pair;
  - frame_range is computed from those values;
  - out_count is loaded with the final count;
  - out_valid is set to 1 and cnt returns to 0.
- Flush with cnt==0 and no accepted pair: no effect, and no empty frame is produced.
- Output hold: result registers and out_valid stay stable while out_valid && !out_ready.
- out_valid clears on an output transfer, unless a new frame closes in the same cycle; in that case out_valid stays 1 and the new result loads.
- in_ready = !rst_d && !(out_valid && !out_ready_pending_free && cnt==FRAME-1), defined concretely as:
  - 0 while out_valid==1 && cnt==FRAME-1, since the next pair would complete a frame with no room;
  - 1 otherwise.
  - in_ready has no combinational path from out_ready.
- Flush while out_valid==1 and the output is not taken that cycle: the flush is ignored (the frame is not closed) and the accumulator is unchanged. The upstream holds flush until it can take effect.
- Reset values: out_valid=0, frame_min=0, frame_max=0, frame_range=0, out_count=0, cnt=0, acc_min=0, acc_max=0.
- in_ready is 0 during the cycle rst is sampled high and is 1 from the first cycle after reset.
- Reset mid-frame discards the partial frame and any pending result.

## Timing
- Throughput: 1 pair/cycle while the consumer keeps up.
- Latency: result visible (out_valid=1) the cycle after the closing transfer or flush edge.
- Back-to-back frames with out_ready held 1: out_valid pulses for one cycle per frame, and no input stall occurs.
- Stall case: with a result pending and cnt==FRAME-1, in_ready drops. It returns to 1 the cycle after the output transfer.
- All outputs are registered.

## Test plan
- FRAME=4, out_ready=1. Pairs (10,20),(5,30),(7,8),(12,25) on consecutive cycles -> one cycle after the 4th pair: out_valid=1, frame_min=5, frame_max=30, frame_range=25, out_count=4. out_valid=0 on the next cycle.
- Backpressure, FRAME=4, out_ready=0, in_valid held 1 -> first result is pending after 4 pairs. in_ready=0 once cnt==3 of frame 2. Raising out_ready for one cycle -> frame 1 result transfers, in_ready returns to 1, and frame 2 completes with correct values and no lost or duplicated pair.
- Flush: pairs (100,200) then (50,60) with flush on the second -> frame_min=50, frame_max=200, frame_range=150, out_count=2. A later flush with cnt==0 and in_valid=0 -> out_valid stays 0.
- Extremes, DATA=8: frame of (0,255) pairs -> range 255. Frame with every value 0x80 -> range 0.
- Reset: accept 2 pairs (1,2),(3,4), assert rst one cycle, then a full frame of (9,9) -> all outputs 0 during and after reset, then result min=9, max=9, count=FRAME.
- Simultaneous output transfer and frame close: out_ready=1 on the cycle frame 2 closes -> out_valid stays 1, frame 2 values replace frame 1 values the next cycle.
